// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: widths, opcodes and fetch FSM encoding.
// Imported by the fetch stage and its next-PC helper.
package mips_pkg;

  localparam int INSTR_W  = 32;
  localparam int OPCODE_W = 6;

  localparam logic [OPCODE_W-1:0] OP_LW  = 6'd0;
  localparam logic [OPCODE_W-1:0] OP_SW  = 6'd1;
  localparam logic [OPCODE_W-1:0] OP_R   = 6'd2;
  localparam logic [OPCODE_W-1:0] OP_BEQ = 6'd3;
  localparam logic [OPCODE_W-1:0] OP_J   = 6'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC: sequential, PC-relative branch or pseudo-direct jump.
// Jump wins over branch; all arithmetic wraps at the PC width.
module pc_next_calc
  import mips_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic [AW-1:0] pc_i,
  input  logic          br_taken_i,
  input  logic [15:0]   br_imm_i,
  input  logic          jmp_en_i,
  input  logic [25:0]   jmp_idx_i,
  output logic [AW-1:0] next_pc_o
);

  logic [AW-1:0] pc4;
  logic [AW-1:0] jaddr;
  logic [AW-1:0] boff;
  logic [27:0]   jlow;
  logic [17:0]   boff18;

  assign pc4    = pc_i + AW'(4);
  assign jlow   = {jmp_idx_i, 2'b00};
  assign boff18 = {br_imm_i, 2'b00};

  // Narrow PCs simply drop the upper bits of the target/offset.
  if (AW > 28) begin : g_jwide
    assign jaddr = {pc4[AW-1:28], jlow};
  end else begin : g_jnarrow
    assign jaddr = jlow[AW-1:0];
  end

  if (AW > 18) begin : g_bwide
    assign boff = {{(AW-18){br_imm_i[15]}}, boff18};
  end else begin : g_bnarrow
    assign boff = boff18[AW-1:0];
  end

  always_comb begin
    next_pc_o = pc4;
    if (jmp_en_i) begin
      next_pc_o = jaddr;
    end else if (br_taken_i) begin
      next_pc_o = pc4 + boff;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: req/ack imem port, valid/ready to decode.
// Define IF_PERF_CNT_EN to build the perf_fetch/perf_stall counters.
module instr_fetch
  import mips_pkg::*;
#(
  parameter int          AW       = 32,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req,
  output logic [AW-1:0]       imem_addr,
  input  logic                imem_ack,
  input  logic [INSTR_W-1:0]  imem_rdata,
  output logic                if_valid,
  input  logic                if_ready,
  output logic [INSTR_W-1:0]  if_instr,
  output logic [OPCODE_W-1:0] if_opcode,
  output logic [AW-1:0]       if_pc,
  input  logic                br_taken,
  input  logic [15:0]         br_imm,
  input  logic                jmp_en,
  input  logic [25:0]         jmp_idx,
  output logic [31:0]         perf_fetch,
  output logic [31:0]         perf_stall
);

  fetch_state_e       state_q, state_d;
  logic [AW-1:0]      pc_q, pc_d;
  logic [AW-1:0]      ifpc_q, ifpc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [AW-1:0]      next_pc;
  logic               hs;

  pc_next_calc #(
    .AW(AW)
  ) u_pc_next (
    .pc_i      (ifpc_q),
    .br_taken_i(br_taken),
    .br_imm_i  (br_imm),
    .jmp_en_i  (jmp_en),
    .jmp_idx_i (jmp_idx),
    .next_pc_o (next_pc)
  );

  assign hs = (state_q == HOLD) && if_ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ifpc_d  = ifpc_q;
    instr_d = instr_q;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          ifpc_d  = pc_q;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (if_ready) begin
          pc_d    = next_pc;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      ifpc_q  <= RESET_PC;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ifpc_q  <= ifpc_d;
      instr_q <= instr_d;
    end
  end

  assign imem_req  = (state_q == REQ);
  assign imem_addr = pc_q;
  assign if_valid  = (state_q == HOLD);
  assign if_instr  = instr_q;
  assign if_opcode = instr_q[31:26];
  assign if_pc     = ifpc_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_q;
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_q <= '0;
      stall_q <= '0;
    end else begin
      if (hs) fetch_q <= fetch_q + 32'd1;
      if (if_valid && !if_ready) stall_q <= stall_q + 32'd1;
    end
  end

  assign perf_fetch = fetch_q;
  assign perf_stall = stall_q;
`else
  assign perf_fetch = 32'd0;
  assign perf_stall = 32'd0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: directed fetch/branch/jump/reset cases.
// A monitor pops expected PCs at each decode handshake.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [5:0]  if_opcode;
  logic [31:0] if_pc;
  logic        br_taken;
  logic [15:0] br_imm;
  logic        jmp_en;
  logic [25:0] jmp_idx;
  logic [31:0] perf_fetch;
  logic [31:0] perf_stall;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_hs = 0;
  int n_deliv = 0;
  int ack_lat = 0;
  int wait_cnt = 0;
  bit force_ack = 1'b0;
  logic [31:0] exp_q[$];

  instr_fetch dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .if_valid  (if_valid),
    .if_ready  (if_ready),
    .if_instr  (if_instr),
    .if_opcode (if_opcode),
    .if_pc     (if_pc),
    .br_taken  (br_taken),
    .br_imm    (br_imm),
    .jmp_en    (jmp_en),
    .jmp_idx   (jmp_idx),
    .perf_fetch(perf_fetch),
    .perf_stall(perf_stall)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5C3_0F00;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Memory model: ack after ack_lat idle REQ cycles; force_ack injects a stray ack.
  initial begin
    imem_ack = 1'b0;
    imem_rdata = '0;
    forever begin
      @(negedge clk);
      imem_ack = 1'b0;
      if (force_ack) begin
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
      end else if (imem_req) begin
        if (wait_cnt >= ack_lat) begin
          imem_ack = 1'b1;
          imem_rdata = mem_word(imem_addr);
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  initial begin
    logic [31:0] e;
    logic [31:0] w;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && if_valid && if_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected delivery: got pc %h expected none", if_pc);
        end else begin
          e = exp_q.pop_front();
          w = mem_word(e);
          chk("if_pc", if_pc, e);
          chk("if_instr", if_instr, w);
          chk("if_opcode", {26'd0, if_opcode}, {26'd0, w[31:26]});
          n_deliv++;
        end
      end
    end
  end

  task automatic deliver(input logic [31:0] addr, input logic br,
                         input logic [15:0] imm, input logic jmp,
                         input logic [25:0] idx);
    int n = 0;
    exp_q.push_back(addr);
    br_taken = br;
    br_imm = imm;
    jmp_en = jmp;
    jmp_idx = idx;
    if_ready = 1'b1;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!if_valid && n < 50);
    if (!if_valid) begin
      checks++;
      errors++;
      $display("FAIL deliver timeout: got no if_valid expected pc %h", addr);
    end else begin
      @(posedge clk);
      #1;
      last_hs = cyc;
    end
    if_ready = 1'b0;
    br_taken = 1'b0;
    jmp_en = 1'b0;
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!if_valid && n < 50);
    chk(nm, {31'd0, if_valid}, 32'd1);
  endtask

  task automatic chk_addr(input string nm, input logic [31:0] a);
    @(negedge clk);
    #1;
    chk({nm, "_req"}, {31'd0, imem_req}, 32'd1);
    chk(nm, imem_addr, a);
  endtask

  initial begin
    int prev;
    logic [31:0] ci;
    logic [31:0] cp;
    if_ready = 1'b0;
    br_taken = 1'b0;
    br_imm = '0;
    jmp_en = 1'b0;
    jmp_idx = '0;

    #12;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_instr", if_instr, 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_pfetch", perf_fetch, 32'd0);
    chk("rst_pstall", perf_stall, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    deliver(32'h0, 1'b0, 16'h0, 1'b0, 26'h0);
    for (int i = 1; i < 4; i++) begin
      prev = last_hs;
      deliver(32'(i * 4), 1'b0, 16'h0, 1'b0, 26'h0);
      chk("spacing", 32'(last_hs - prev), 32'd2);
    end

    wait_valid("stall_valid");
    ci = if_instr;
    cp = if_pc;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("stall_instr", if_instr, ci);
      chk("stall_pc", if_pc, cp);
      chk("stall_noreq", {31'd0, imem_req}, 32'd0);
    end
`ifdef IF_PERF_CNT_EN
    chk("perf_stall5", perf_stall, 32'd5);
    chk("perf_fetch4", perf_fetch, 32'd4);
`else
    chk("perf_stall_off", perf_stall, 32'd0);
`endif

    deliver(32'h10, 1'b1, 16'hFFFC, 1'b0, 26'h0);
    chk_addr("br_back", 32'h4);
    deliver(32'h4, 1'b1, 16'h0002, 1'b0, 26'h0);
    deliver(32'h10, 1'b1, 16'h0003, 1'b0, 26'h0);
    chk_addr("br_fwd", 32'h20);

    deliver(32'h20, 1'b0, 16'h0, 1'b1, 26'h3FF_FFFF);
    deliver(32'h0FFF_FFFC, 1'b0, 16'h0, 1'b0, 26'h0);
    deliver(32'h1000_0000, 1'b1, 16'h000F, 1'b0, 26'h0);
    ack_lat = 3;
    deliver(32'h1000_0040, 1'b1, 16'h0001, 1'b1, 26'h000_0100);
    chk_addr("jmp_prio", 32'h1000_0400);

    rst_n = 1'b0;
    #1;
    chk("rst2_req", {31'd0, imem_req}, 32'd0);
    chk("rst2_valid", {31'd0, if_valid}, 32'd0);
    chk("rst2_addr", imem_addr, 32'd0);
    chk("rst2_pc", if_pc, 32'd0);
    chk("rst2_instr", if_instr, 32'd0);
    chk("rst2_pfetch", perf_fetch, 32'd0);
    n_deliv = 0;
    @(negedge clk);
    ack_lat = 0;
    rst_n = 1'b1;

    deliver(32'h0, 1'b1, 16'hFFFE, 1'b0, 26'h0);
    wait_valid("spur_valid");
    @(negedge clk);
    #1;
    force_ack = 1'b1;
    @(negedge clk);
    #1;
    force_ack = 1'b0;
    @(posedge clk);
    #1;
    chk("spur_instr", if_instr, mem_word(32'hFFFF_FFFC));
    chk("spur_pc", if_pc, 32'hFFFF_FFFC);
    chk("spur_valid2", {31'd0, if_valid}, 32'd1);
    deliver(32'hFFFF_FFFC, 1'b0, 16'h0, 1'b0, 26'h0);
    chk_addr("wrap", 32'h0);
    deliver(32'h0, 1'b0, 16'h0, 1'b0, 26'h0);

    repeat (3) @(negedge clk);
    chk("drained", 32'(exp_q.size()), 32'd0);
`ifdef IF_PERF_CNT_EN
    chk("perf_fetch_end", perf_fetch, 32'(n_deliv));
    chk("perf_stall_end", perf_stall, 32'd3);
`else
    chk("perf_fetch_off", perf_fetch, 32'd0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
